inst_fetch: RTL and testbench

//  Instruction fetch stage sitting directly upstream of the byte-addressed combinational instruction memory.

---
 rtl/rv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/inst_fetch.sv | 95 +++++++++
 tb/tb_inst_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V fetch-side types and constants.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  typedef enum logic {FS_RUN, FS_FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-2 FIFO of {pc,inst} fetch packets; flush beats push and pop.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  fetch_pkt_t push_pkt,
  output fetch_pkt_t head_pkt,
  output logic       full,
  output logic       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_pkt_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_pkt = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_pkt;
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, queues {pc,inst} toward decode, flags illegal fetches.
// Optional zero-latency empty-queue bypass is enabled by defining FETCH_BYPASS_EN.
//
// state    | meaning
// FS_RUN   | fetching; current pc checked for legality every cycle
// FS_FAULT | fetch stopped, pc frozen on the offending address; leave via redirect or rst
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_NBYTE = 4096,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        fault
);
  localparam logic [31:0] LAST_PC = 32'(MEM_NBYTE - 4);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         pc_legal;
  logic         fetch_ok;
  logic         q_push;
  logic         q_pop;
  logic         q_full;
  logic         q_empty;
  logic         byp_take;
  logic         byp_consume;
  logic         advance;
  fetch_pkt_t   head_pkt;
  fetch_pkt_t   push_pkt;

  assign pc_legal = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
  assign fetch_ok = (state == FS_RUN) && pc_legal && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign byp_take    = q_empty && fetch_ok;
  assign byp_consume = byp_take && out_ready;
`else
  assign byp_take    = 1'b0;
  assign byp_consume = 1'b0;
`endif

  // Redirect cancels the pop so the flushed head is never seen as consumed.
  assign q_pop    = !q_empty && out_ready && !redirect_valid;
  assign q_push   = fetch_ok && !byp_consume && (!q_full || q_pop);
  assign advance  = q_push || byp_consume;
  assign push_pkt = '{pc: pc, inst: imem_inst};

  fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (q_push),
    .pop      (q_pop),
    .push_pkt (push_pkt),
    .head_pkt (head_pkt),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_RUN;
      pc    <= RESET_PC;
    end else if (redirect_valid) begin
      state <= FS_RUN;
      pc    <= redirect_pc;
    end else begin
      case (state)
        FS_RUN: begin
          if (!pc_legal)    state <= FS_FAULT;
          else if (advance) pc    <= pc + 32'd4;
        end
        FS_FAULT: state <= FS_FAULT;
        default:  state <= FS_FAULT;
      endcase
    end
  end

  assign imem_addr = pc;
  assign fault     = (state == FS_FAULT);
  assign out_valid = !q_empty || byp_take;
  assign out_pc    = !q_empty ? head_pkt.pc   : (byp_take ? pc        : 32'h0);
  assign out_inst  = !q_empty ? head_pkt.inst : (byp_take ? imem_inst : 32'h0);
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-level reference model checked every cycle, directed scenarios, random traffic.
module tb_inst_fetch;
  import rv_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          MEM_NBYTE = 4096;
  localparam int          QDEPTH    = 2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        fault;

  logic [31:0] mem [0:1023];
  logic [31:0] prog [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .MEM_NBYTE(MEM_NBYTE), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .fault          (fault)
  );

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a < 32'(MEM_NBYTE)) return mem[a[11:2]];
    return 32'hBAD0_0000 ^ a;
  endfunction

  always_comb imem_inst = mem_word(imem_addr);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of {pc,inst}, a pc and a fault flag.
  fetch_pkt_t  mq[$];
  logic [31:0] mpc = 32'h0;
  bit          mfault = 1'b0;
  bit          model_ok = 1'b0;
  logic [31:0] log_q[$];

  function automatic bit legal(logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(MEM_NBYTE - 4));
  endfunction

  function automatic bit m_byp();
`ifdef FETCH_BYPASS_EN
    return (mq.size() == 0) && !mfault && legal(mpc) && !redirect_valid;
`else
    return 1'b0;
`endif
  endfunction

  always begin
    bit         exp_v, took_byp, popped, was_full;
    fetch_pkt_t exp_pkt;
    @(negedge clk);
    if (model_ok) begin
      chk("imem_addr", imem_addr, mpc);
      chk("fault", {31'b0, fault}, {31'b0, mfault});
      exp_v = (mq.size() > 0) || m_byp();
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      if (exp_v) begin
        exp_pkt = (mq.size() > 0) ? mq[0] : fetch_pkt_t'{pc: mpc, inst: mem_word(mpc)};
        chk("out_pc", out_pc, exp_pkt.pc);
        chk("out_inst", out_inst, exp_pkt.inst);
      end
    end
    if (out_valid === 1'b1 && out_ready && !redirect_valid && !rst) log_q.push_back(out_pc);
    // advance model with the inputs the DUT samples at the coming edge
    if (rst) begin
      mq.delete();
      mpc      = RESET_PC;
      mfault   = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (redirect_valid) begin
        mq.delete();
        mpc    = redirect_pc;
        mfault = 1'b0;
      end else begin
        took_byp = m_byp() && out_ready;
        popped   = (mq.size() > 0) && out_ready;
        was_full = (mq.size() >= QDEPTH);
        if (popped) void'(mq.pop_front());
        if (!mfault) begin
          if (!legal(mpc)) mfault = 1'b1;
          else if (took_byp) mpc = mpc + 32'd4;
          else if (!was_full || popped) begin
            mq.push_back(fetch_pkt_t'{pc: mpc, inst: mem_word(mpc)});
            mpc = mpc + 32'd4;
          end
        end
      end
    end
  end

  task automatic cyc(bit r, bit rv, logic [31:0] rp, bit rd);
    rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rd;
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    bit r, rv, rd;
    logic [31:0] rp;
    int sel;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    prog[0] = 32'h0000_0093;
    prog[1] = 32'h0050_0113;
    prog[2] = 32'h0010_8093;
    prog[3] = 32'hFE20_CCE3;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];

    // 1: straight-line fetch from reset
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    rst = 1'b0;
    chk("t1_fault_rst", {31'b0, fault}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idx = k - LAT;
      if (idx < 0) begin
        chk("t1_valid0", {31'b0, out_valid}, 32'd0);
        chk("t1_pc0", out_pc, 32'h0);
      end else if (idx < 4) begin
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_pc", out_pc, 32'(idx * 4));
        chk("t1_inst", out_inst, prog[idx]);
      end
      @(posedge clk); #1;
    end

    // 2: stall fills the queue, then drain in order
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);
    chk("t2_addr_hold", imem_addr, 32'h8);
    chk("t2_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_head", out_pc, 32'h0);
    log_q.delete();
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);
    chk("t2_count", 32'(log_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < log_q.size(); k++) chk("t2_order", log_q[k], 32'(k * 4));

    // 3: redirect while full and ready
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    log_q.delete();
    cyc(0, 1, 32'h10, 1);
    chk("t3_nopop", 32'(log_q.size()), 32'd0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);
    chk("t3_any", {31'b0, log_q.size() != 0}, 32'd1);
    if (log_q.size() != 0) chk("t3_first", log_q[0], 32'h10);

    // 4: misaligned target faults, recover with redirect
    cyc(0, 1, 32'h12, 1);
    log_q.delete();
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);
    chk("t4_fault", {31'b0, fault}, 32'd1);
    chk("t4_nodeliv", 32'(log_q.size()), 32'd0);
    cyc(0, 1, 32'h0, 1);
    chk("t4_clear", {31'b0, fault}, 32'd0);
    log_q.delete();
    for (int k = 0; k < 2; k++) cyc(0, 0, 0, 1);
    chk("t4_any", {31'b0, log_q.size() != 0}, 32'd1);
    if (log_q.size() != 0) chk("t4_first", log_q[0], 32'h0);

    // 5: run off the end of memory
    cyc(0, 1, 32'hFF8, 1);
    log_q.delete();
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1);
    chk("t5_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      chk("t5_a", log_q[0], 32'hFF8);
      chk("t5_b", log_q[1], 32'hFFC);
    end
    chk("t5_fault", {31'b0, fault}, 32'd1);
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_addr", imem_addr, 32'h1000);

    // 6: reset with a full queue
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", {31'b0, out_valid}, LAT == 1 ? 32'd0 : 32'd1);
    if (LAT == 1) chk("t6_pc", out_pc, 32'h0);
    chk("t6_addr", imem_addr, RESET_PC);
    chk("t6_fault", {31'b0, fault}, 32'd0);
    @(posedge clk); #1;

    // random traffic, model compare runs every cycle
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 19) == 0);
      rd = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rp = (32'($urandom_range(0, 1023)) << 2) | 32'd2;
        1:       rp = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
        2:       rp = 32'hFF0 + (32'($urandom_range(0, 3)) << 2);
        default: rp = 32'($urandom_range(0, 1023)) << 2;
      endcase
      cyc(r, rv, rp, rd);
    end
    cyc(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
